// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, defaults and baud divider computation
package uart_pkg;
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
   localparam int DEFAULT_CLK_HZ = 100_000_000;
   localparam int DEFAULT_BAUD = 115200;
   localparam int OVERSAMPLE = 16;
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + (OVERSAMPLE / 2) * baud) / (OVERSAMPLE * baud);
   endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversample tick divider with phase restart
module uart_baud_gen #(
   parameter int DIV = 54
) (
   input  logic clk_100,
   input  logic rst_n,
   input  logic restart,
   output logic tick
);
   localparam int W = $clog2(DIV + 1);
   logic [W-1:0] cnt;
   assign tick = cnt == W'(DIV - 1);
   // free-running count, forced back to phase 0 on restart
   always_ff @(posedge clk_100 or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (restart || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 receiver with 16x oversampling, majority vote and valid/ready holding register
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_HZ = DEFAULT_CLK_HZ,
   parameter int BAUD = DEFAULT_BAUD
) (
   input  logic       clk_100,
   input  logic       rst_n,
   input  logic       rx,
   input  logic       ready,
   output logic [7:0] data,
   output logic       valid,
   output logic       frame_err,
   output logic       overrun
);
   localparam int DIV = calc_div(CLK_HZ, BAUD);
   uart_state_t state, state_nxt;
   logic rx_meta, rx_s, rx_prev;
   logic [3:0] tcnt;
   logic [2:0] bit_idx;
   logic [1:0] samp;
   logic [7:0] shreg;
   logic tick, fall, restart, maj, at_mid, at_end, stop_ok, stop_bad, load;
   uart_baud_gen #(.DIV(DIV)) u_baud (
      .clk_100(clk_100),
      .rst_n(rst_n),
      .restart(restart),
      .tick(tick)
   );
   assign fall = rx_prev & ~rx_s;
   assign restart = (state == IDLE) & fall;
   assign maj = (samp[1] & samp[0]) | (samp[1] & rx_s) | (samp[0] & rx_s);
   assign at_mid = tick && tcnt == 4'd9;
   assign at_end = tick && tcnt == 4'd15;
   assign stop_ok = (state == STOP) & at_mid & maj;
   assign stop_bad = (state == STOP) & at_mid & ~maj;
   assign load = stop_ok & (~valid | ready);
   // next-state: frame sequencing, stop returns to idle right at the mid-bit decision
   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:  state_nxt = fall ? START : IDLE;
         START: state_nxt = (at_mid && maj) ? IDLE : (at_end ? DATA : START);
         DATA:  state_nxt = (at_end && bit_idx == 3'd7) ? STOP : DATA;
         STOP:  state_nxt = at_mid ? IDLE : STOP;
         default: state_nxt = IDLE;
      endcase
   end
   // state register
   always_ff @(posedge clk_100 or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else state <= state_nxt;
   // line synchronizer plus one extra stage for falling-edge detection, idle high
   always_ff @(posedge clk_100 or negedge rst_n)
      if (!rst_n) {rx_meta, rx_s, rx_prev} <= 3'b111;
      else {rx_meta, rx_s, rx_prev} <= {rx, rx_meta, rx_s};
   // tick counter, mid-bit samples, bit index and shift register
   always_ff @(posedge clk_100 or negedge rst_n)
      if (!rst_n) begin
         tcnt <= '0;
         bit_idx <= '0;
         samp <= '0;
         shreg <= '0;
      end else begin
         tcnt <= restart ? 4'd0 : (tick ? tcnt + 4'd1 : tcnt);
         bit_idx <= restart ? 3'd0 : ((state == DATA && at_end) ? bit_idx + 3'd1 : bit_idx);
         if (tick && tcnt == 4'd7) samp[1] <= rx_s;
         if (tick && tcnt == 4'd8) samp[0] <= rx_s;
         if (state == DATA && at_mid) shreg <= {maj, shreg[7:1]};
      end
   // holding register handshake and one-cycle error pulses
   always_ff @(posedge clk_100 or negedge rst_n)
      if (!rst_n) begin
         data <= '0;
         valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         if (load) data <= shreg;
         valid <= load | (valid & ~ready);
         frame_err <= stop_bad;
         overrun <= stop_ok & ~load;
      end
endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_HZ, default 100_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, line bit rate.
REQ-003 clk_100  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rx  input  1  asynchronous serial line (ftdi_rx), idle high, 8N1 LSB-first.
REQ-006 data  output  8  received byte, stable while valid is high.
REQ-007 valid  output  1  byte available; held until accepted.
REQ-008 ready  input  1  consumer accepts data on a cycle where valid and ready are both high.
REQ-009 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-010 overrun  output  1  one-cycle pulse: completed byte dropped because the holding register was full.

Function
REQ-011 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (2-cycle input latency).
REQ-012 Oversample tick SHALL be generated every DIV = (CLK_HZ + 8*BAUD)/(16*BAUD) clocks (54 at defaults), integer arithmetic at elaboration.
REQ-013 Per bit, a 4-bit tick counter SHALL run 0..15; samples taken at ticks 7, 8, 9; bit value = majority of the three, decided at tick 9.
REQ-014 States: IDLE, START, DATA, STOP.
REQ-015 IDLE: a synchronized 1->0 transition SHALL enter START, reset the tick divider phase and tick counter to 0.
REQ-016 START: if the majority at tick 9 is 1 (false start/glitch), SHALL return to IDLE with no output; else continue to DATA at the end of tick 15.
REQ-017 DATA: 8 bits SHALL be shifted in LSB-first with a 3-bit bit index; after bit 7 at tick 15, go to STOP.
REQ-018 STOP: decision at tick 9 of the stop bit; state SHALL return to IDLE on the next clock (no wait for tick 15) to allow resynchronization.
REQ-019 Stop majority 1: if valid is low, or valid and ready are both high that cycle, load data and set valid; otherwise pulse overrun, keep the old byte.
REQ-020 Stop majority 0: pulse frame_err, discard the byte, valid unchanged; a new frame requires a fresh 1->0 edge.
REQ-021 valid SHALL clear on a cycle with valid and ready high unless a new byte is loaded that same cycle (then valid stays 1 with new data).
REQ-022 frame_err and overrun SHALL never assert in the same cycle and are each exactly one cycle wide.
REQ-023 rx edges during START/DATA/STOP SHALL not restart the frame.

Reset
REQ-024 While rst_n low: state IDLE, counters 0, shift register 0, data 8'h00, valid 0, frame_err 0, overrun 0, synchronizer flops 1.
REQ-025 Reset assertion mid-frame SHALL abandon the frame with no output; after release, reception starts only on a new 1->0 edge.
REQ-026 Reset release is synchronous to clk_100 by the system reset path; no internal release synchronizer.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state enum, DEFAULT_CLK_HZ, DEFAULT_BAUD, OVERSAMPLE = 16, and the DIV computation function, for reuse by the transmitter.
REQ-028 Sub-module uart_baud_gen (divider with phase-restart input, tick output) SHALL be instantiated once.

Verification
REQ-029 Byte 0x55 at 115200 (864 clocks/bit), ready held high -> valid pulses 1 cycle with data 0x55, no flags.
REQ-030 Low glitch of 300 clocks on idle line -> no valid, no frame_err, state back to IDLE; next 0xA3 frame received correctly.
REQ-031 Frame 0xA3 with stop bit low -> frame_err pulses once, valid stays 0; following 0x3C received correctly.
REQ-032 ready held low, send 0x11 then 0x22 -> valid high with 0x11, overrun pulses once at 0x22's stop decision, data remains 0x11.
REQ-033 ready high exactly on the cycle 0x22 completes while 0x11 pending -> data 0x22, valid stays 1, no overrun.
REQ-034 rst_n low for 10 clocks during bit 4 of a frame -> all outputs reset values; next full 0x7E frame received correctly.
